// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 8-channel TDM demultiplexer.
package tdm_demux_pkg;

  localparam int CHANNELS = 8;
  localparam int SLOT_W   = 3;
  localparam logic [SLOT_W-1:0] LAST_SLOT = 3'd7;

  typedef enum logic {
    HUNT   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_capture_bank.sv
// Per-channel shadow registers plus the published frame register.
module tdm_capture_bank
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [SLOT_W-1:0]         wr_slot,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      publish,
  output logic [CHANNELS*WIDTH-1:0] pub_data
);

  // Slot 7 never needs a shadow: its beat goes straight into the published word.
  logic [WIDTH-1:0]          shadow_q [CHANNELS-1];
  logic [CHANNELS*WIDTH-1:0] pub_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS - 1; k++) shadow_q[k] <= '0;
      pub_q <= '0;
    end else begin
      if (wr_en && (wr_slot != LAST_SLOT)) shadow_q[wr_slot] <= wr_data;
      if (publish) begin
        for (int k = 0; k < CHANNELS - 1; k++) pub_q[k*WIDTH +: WIDTH] <= shadow_q[k];
        pub_q[(CHANNELS-1)*WIDTH +: WIDTH] <= wr_data;
      end
    end
  end

  assign pub_data = pub_q;

endmodule

// File: rtl/tdm_demux_8ch.sv
// 8-channel TDM receiver: slot tracking FSM with frame publish and framing-error resync.
module tdm_demux_8ch
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_sync,
  input  logic [WIDTH-1:0]          in_data,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  output logic                      locked,
  output logic [SLOT_W-1:0]         slot,
  output logic                      frame_err
);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              wr_en;
  logic [SLOT_W-1:0] wr_slot;
  logic              publish;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      slot_q      <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;
    wr_slot     = slot_q;
    publish     = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_sync) begin
            wr_en   = 1'b1;
            wr_slot = '0;
            slot_d  = 3'd1;
            state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          if (in_sync) begin
            // A sync anywhere but slot 0 is a short frame; restart on this beat.
            frame_err_d = (slot_q != '0);
            wr_en       = 1'b1;
            wr_slot     = '0;
            slot_d      = 3'd1;
          end else if (slot_q == '0) begin
            frame_err_d = 1'b1;
            state_d     = HUNT;
            slot_d      = '0;
          end else if (slot_q == LAST_SLOT) begin
            publish     = 1'b1;
            out_valid_d = 1'b1;
            slot_d      = '0;
          end else begin
            wr_en  = 1'b1;
            slot_d = slot_q + 3'd1;
          end
        end
        default: begin
          state_d = HUNT;
          slot_d  = '0;
        end
      endcase
    end
  end

  tdm_capture_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_slot  (wr_slot),
    .wr_data  (in_data),
    .publish  (publish),
    .pub_data (out_data)
  );

  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign locked    = (state_q == ACTIVE);
  assign slot      = slot_q;

endmodule
